// File: rtl/aurora_link_supervisor.sv
// Bring-up and recovery sequencer for one Aurora lane: times gt_reset/reset,
// qualifies channel_up, and retries failed attempts before latching a fail flag.
module aurora_link_supervisor #(
    parameter int GT_HOLD    = 128,
    parameter int RST_HOLD   = 64,
    parameter int STABLE_CYC = 8,
    parameter int UP_TIMEOUT = 4096,
    parameter int MAX_RETRY  = 3,
    parameter int CNT_W      = 13
) (
    input  logic       init_clk,
    input  logic       RST_n,
    input  logic       channel_up,
    input  logic       hard_err,
    input  logic       retrain_req,
    output logic       reset_aurora,
    output logic       gt_reset,
    output logic       reset_tx_rx_block,
    output logic       link_up,
    output logic       link_fail,
    output logic [1:0] retry_cnt,
    output logic [2:0] state_o
);

    localparam logic [2:0] ST_RESET   = 3'd0;
    localparam logic [2:0] ST_GT_REL  = 3'd1;
    localparam logic [2:0] ST_WAIT_UP = 3'd2;
    localparam logic [2:0] ST_LINK_UP = 3'd3;
    localparam logic [2:0] ST_FAIL    = 3'd4;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] GT_LAST  = CNT_W'(GT_HOLD - 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(UP_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE   = CNT_W'(STABLE_CYC);
    localparam logic [1:0]       RETRY_MX = 2'(MAX_RETRY);

    logic             ch_meta, ch_s, he_meta, he_s;
    logic [2:0]       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] stab, stab_nx;
    logic [1:0]       retry_nx;
    logic             fail_evt;

    always_ff @(posedge init_clk or negedge RST_n) begin
        if (!RST_n) begin
            ch_meta <= 1'b0;
            ch_s    <= 1'b0;
            he_meta <= 1'b0;
            he_s    <= 1'b0;
        end else begin
            ch_meta <= channel_up;
            ch_s    <= ch_meta;
            he_meta <= hard_err;
            he_s    <= he_meta;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + CNT_ONE;
        stab_nx  = stab;
        retry_nx = retry_cnt;
        fail_evt = 1'b0;
        case (state)
            ST_RESET: begin
                if (cnt == GT_LAST) state_nx = ST_GT_REL;
            end
            ST_GT_REL: begin
                if (cnt == RST_LAST) state_nx = ST_WAIT_UP;
            end
            ST_WAIT_UP: begin
                stab_nx = ch_s ? stab + CNT_ONE : '0;
                // a stable link on the last timeout cycle still counts as up
                if (stab_nx == STABLE)   state_nx = ST_LINK_UP;
                else if (cnt == TO_LAST) fail_evt = 1'b1;
            end
            ST_LINK_UP: begin
                if (!ch_s || he_s) fail_evt = 1'b1;
            end
            ST_FAIL: begin
                state_nx = ST_FAIL;
            end
            default: begin
                state_nx = ST_RESET;
            end
        endcase

        if (fail_evt) begin
            if (retry_cnt == RETRY_MX) begin
                state_nx = ST_FAIL;
            end else begin
                retry_nx = retry_cnt + 2'd1;
                state_nx = ST_RESET;
            end
        end

        if (state_nx == ST_LINK_UP && state != ST_LINK_UP) retry_nx = 2'd0;

        if (retrain_req) begin
            state_nx = ST_RESET;
            retry_nx = 2'd0;
        end

        // counters restart on every state change and never run in the idle states
        if (state_nx != state || retrain_req || state == ST_LINK_UP || state == ST_FAIL)
            cnt_nx = '0;
        if (state_nx != ST_WAIT_UP || retrain_req)
            stab_nx = '0;
    end

    always_ff @(posedge init_clk or negedge RST_n) begin
        if (!RST_n) begin
            state             <= ST_RESET;
            cnt               <= '0;
            stab              <= '0;
            retry_cnt         <= 2'd0;
            reset_aurora      <= 1'b1;
            gt_reset          <= 1'b1;
            reset_tx_rx_block <= 1'b1;
            link_up           <= 1'b0;
            link_fail         <= 1'b0;
        end else begin
            state             <= state_nx;
            cnt               <= cnt_nx;
            stab              <= stab_nx;
            retry_cnt         <= retry_nx;
            reset_aurora      <= (state_nx == ST_RESET) || (state_nx == ST_GT_REL) ||
                                 (state_nx == ST_FAIL);
            gt_reset          <= (state_nx == ST_RESET) || (state_nx == ST_FAIL);
            reset_tx_rx_block <= (state_nx != ST_LINK_UP);
            link_up           <= (state_nx == ST_LINK_UP);
            link_fail         <= (state_nx == ST_FAIL);
        end
    end

    assign state_o = state;

endmodule
